// File: rtl/serial_adder_if.sv
// Start/busy/done bus between a controlling FSM and the bit-serial adder.
interface serial_adder_if #(parameter int N = 4);
  logic         start;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [N-1:0] s;
  logic         cout;

  // Controller side: requests an addition and observes the result.
  modport master (output start, a, b, cin, input busy, done, s, cout);
  // Adder side.
  modport slave  (input start, a, b, cin, output busy, done, s, cout);
endinterface

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: one full-adder cell plus a carry flop, LSB first.
//
// Handshake: start is sampled on each rising edge and is accepted only when
// the block is idle or presenting a result (busy=0). a/b/cin are captured on
// the accepting edge and ignored otherwise. busy is high for exactly N cycles
// while bits resolve; done then pulses for one cycle with s/cout valid. s/cout
// hold their last result until the next completion. Holding start high during
// the done cycle starts the next addition immediately (one result per N+1
// cycles). start while busy is dropped, never queued.
module serial_adder #(
  parameter int N = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_adder_if.slave      bus,
  output logic [1:0]         dbg_state
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic            accept;
  logic            step;
  logic            last;

  logic [N-1:0]    a_sr;
  logic [N-1:0]    b_sr;
  logic [N-1:0]    s_sr;
  logic            c;
  logic [CW-1:0]   cnt;
  logic [N-1:0]    s_q;
  logic            cout_q;
  logic            busy_q;
  logic            done_q;

  logic            x;
  logic            c_nxt;

  // Single full-adder cell working on the current LSBs.
  assign x     = a_sr[0] ^ b_sr[0] ^ c;
  assign c_nxt = (a_sr[0] & b_sr[0]) | (c & (a_sr[0] ^ b_sr[0]));
  assign last  = (cnt == CW'(N - 1));

  // Next-state and control strobes.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register; busy/done are registered from the next state so they
  // leave the block straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= (state_nxt == RUN);
      done_q <= (state_nxt == DONE);
    end
  end

  // Operand capture, bit-serial datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr   <= '0;
      b_sr   <= '0;
      s_sr   <= '0;
      c      <= 1'b0;
      cnt    <= '0;
      s_q    <= '0;
      cout_q <= 1'b0;
    end else if (accept) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      s_sr <= '0;
      c    <= bus.cin;
      cnt  <= '0;
    end else if (step) begin
      a_sr <= a_sr >> 1;
      b_sr <= b_sr >> 1;
      s_sr <= {x, s_sr[N-1:1]};
      c    <= c_nxt;
      cnt  <= cnt + 1'b1;
      // The Nth bit: publish the completed sum including this edge's bit.
      if (last) begin
        s_q    <= {x, s_sr[N-1:1]};
        cout_q <= c_nxt;
      end
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.s     = s_q;
  assign bus.cout  = cout_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (N=4 directed/exhaustive, N=8 random).
module tb_serial_adder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] dbg4;
  logic [1:0] dbg8;

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  serial_adder_if #(.N(4)) bus4();
  serial_adder_if #(.N(8)) bus8();

  serial_adder #(.N(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(bus4), .dbg_state(dbg4));
  serial_adder #(.N(8)) u8 (.clk(clk), .rst_n(rst_n), .bus(bus8), .dbg_state(dbg8));

  // Clock and reset.
  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // Driver: one N=4 addition from an idle cycle; returns the observations
  // at the negedge where done is seen (or after the cycle budget runs out).
  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic cin,
                        output logic [3:0] rs, output logic rc,
                        output int busy_cycles, output bit done_seen);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.cin = cin;
    @(negedge clk);
    bus4.start = 1'b0; bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.cin = 1'($urandom);
    busy_cycles = 0;
    done_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.done) begin
        done_seen = 1'b1;
        break;
      end
      if (bus4.busy) busy_cycles++;
      @(negedge clk);
    end
    rs = bus4.s;
    rc = bus4.cout;
  endtask

  // Driver for the N=8 instance.
  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        output logic [7:0] rs, output logic rc, output bit done_seen);
    @(negedge clk);
    bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.cin = cin;
    @(negedge clk);
    bus8.start = 1'b0; bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    done_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (bus8.done) begin
        done_seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    rs = bus8.s;
    rc = bus8.cout;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus4.busy, bus4.done, bus4.s, bus4.cout} !== 7'd0) begin
      failures++;
      $display("FAIL reset_n4 got busy=%b done=%b s=%h cout=%b expected all 0",
               bus4.busy, bus4.done, bus4.s, bus4.cout);
    end
    apply_reset();
    checks++;
    if ({bus8.busy, bus8.done, bus8.s, bus8.cout} !== 11'd0) begin
      failures++;
      $display("FAIL reset_n8 got busy=%b done=%b s=%h cout=%b expected all 0",
               bus8.busy, bus8.done, bus8.s, bus8.cout);
    end
  endtask

  task automatic test_basic();
    logic [3:0] rs; logic rc; int bc; bit ds;
    drive4(4'b0111, 4'b0101, 1'b0, rs, rc, bc, ds);
    checks++;
    if (!ds || rs !== 4'b1100 || rc !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum got done=%b s=%b cout=%b expected done=1 s=1100 cout=0", ds, rs, rc);
    end
    checks++;
    if (bc !== 4) begin
      failures++;
      $display("FAIL basic_busy_len got %0d expected 4", bc);
    end
    checks++;
    if (bus4.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy_in_done got %b expected 0", bus4.busy);
    end
    @(negedge clk);
    checks++;
    if (bus4.done !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_pulse got done=%b one cycle later expected 0", bus4.done);
    end
  endtask

  task automatic test_carry();
    logic [3:0] rs; logic rc; int bc; bit ds;
    drive4(4'b1111, 4'b0001, 1'b0, rs, rc, bc, ds);
    checks++;
    if (!ds || rs !== 4'b0000 || rc !== 1'b1) begin
      failures++;
      $display("FAIL carry_wrap got done=%b s=%b cout=%b expected done=1 s=0000 cout=1", ds, rs, rc);
    end
    drive4(4'b1111, 4'b1111, 1'b1, rs, rc, bc, ds);
    checks++;
    if (!ds || rs !== 4'b1111 || rc !== 1'b1) begin
      failures++;
      $display("FAIL carry_max got done=%b s=%b cout=%b expected done=1 s=1111 cout=1", ds, rs, rc);
    end
  endtask

  task automatic test_ignore_start();
    logic [3:0] rs; logic rc; int bc; bit ds; int held_bad;
    // Known previous result: 10+3+1 = 14.
    drive4(4'hA, 4'h3, 1'b1, rs, rc, bc, ds);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'h6; bus4.b = 4'h9; bus4.cin = 1'b1;
    @(negedge clk);
    ds = 1'b0; bc = 0; held_bad = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.done) begin
        ds = 1'b1;
        break;
      end
      if (bus4.busy) bc++;
      if (bus4.s !== 4'hE || bus4.cout !== 1'b0) held_bad++;
      bus4.start = 1'b1; bus4.a = 4'b0001; bus4.b = 4'b0001; bus4.cin = 1'b0;
      @(negedge clk);
    end
    bus4.start = 1'b0;
    checks++;
    if (held_bad != 0) begin
      failures++;
      $display("FAIL ignore_hold got %0d cycles with s/cout changed during RUN expected 0", held_bad);
    end
    checks++;
    if (!ds || bc != 4 || bus4.s !== 4'h0 || bus4.cout !== 1'b1) begin
      failures++;
      $display("FAIL ignore_result got done=%b busy_cycles=%0d s=%b cout=%b expected 1 4 0000 1",
               ds, bc, bus4.s, bus4.cout);
    end
  endtask

  task automatic test_back_to_back();
    bit ds; int k; bit busy_bad;
    @(negedge clk);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'b0111; bus4.b = 4'b0101; bus4.cin = 1'b0;
    @(negedge clk);
    bus4.start = 1'b0;
    ds = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus4.done) begin
        ds = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checks++;
    if (!ds || bus4.s !== 4'b1100 || bus4.cout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_first got done=%b s=%b cout=%b expected 1 1100 0", ds, bus4.s, bus4.cout);
    end
    // Hold start through the done cycle with the second operand set.
    bus4.start = 1'b1; bus4.a = 4'b0010; bus4.b = 4'b0011; bus4.cin = 1'b1;
    k = 0; ds = 1'b0; busy_bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        bus4.start = 1'b0;
        if (bus4.busy !== 1'b1) busy_bad = 1'b1;
      end
      if (bus4.done) begin
        ds = 1'b1;
        break;
      end
    end
    checks++;
    if (busy_bad) begin
      failures++;
      $display("FAIL b2b_restart got busy=0 right after done expected busy=1");
    end
    checks++;
    if (!ds || k != 5 || bus4.s !== 4'b0110 || bus4.cout !== 1'b0) begin
      failures++;
      $display("FAIL b2b_second got done=%b gap=%0d s=%b cout=%b expected 1 5 0110 0",
               ds, k, bus4.s, bus4.cout);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [3:0] rs; logic rc; int bc; bit ds; int stray;
    drive4(4'h3, 4'h4, 1'b0, rs, rc, bc, ds);
    @(negedge clk);
    bus4.start = 1'b1; bus4.a = 4'h5; bus4.b = 4'h6; bus4.cin = 1'b0;
    @(negedge clk);
    bus4.start = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus4.busy, bus4.done, bus4.s, bus4.cout} !== 7'd0) begin
      failures++;
      $display("FAIL midrst_clear got busy=%b done=%b s=%b cout=%b expected all 0",
               bus4.busy, bus4.done, bus4.s, bus4.cout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus4.done !== 1'b0 || bus4.busy !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL midrst_no_done got %0d cycles with busy/done set expected 0", stray);
    end
    drive4(4'h5, 4'h6, 1'b1, rs, rc, bc, ds);
    checks++;
    if (!ds || rs !== 4'hC || rc !== 1'b0) begin
      failures++;
      $display("FAIL midrst_after got done=%b s=%h cout=%b expected 1 c 0", ds, rs, rc);
    end
  endtask

  task automatic test_exhaustive_n4();
    logic [3:0] rs; logic rc; int bc; bit ds; logic [4:0] e;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          e = 5'(ia) + 5'(ib) + 5'(ic);
          drive4(4'(ia), 4'(ib), 1'(ic), rs, rc, bc, ds);
          checks++;
          if (!ds || {rc, rs} !== e || bc != 4) begin
            failures++;
            $display("FAIL exh_n4 a=%h b=%h cin=%0d got done=%b busy=%0d {cout,s}=%h expected 1 4 %h",
                     ia, ib, ic, ds, bc, {rc, rs}, e);
          end
        end
      end
    end
  endtask

  task automatic test_random_n8();
    logic [7:0] a, b, rs; logic cin, rc; bit ds; logic [8:0] e;
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      exp_q.push_back(9'(a) + 9'(b) + 9'(cin));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      drive8(a, b, cin, rs, rc, ds);
      e = exp_q.pop_front();
      checks++;
      if (!ds || {rc, rs} !== e) begin
        failures++;
        $display("FAIL rand_n8 a=%h b=%h cin=%b got done=%b {cout,s}=%h expected 1 %h",
                 a, b, cin, ds, {rc, rs}, e);
      end
    end
  endtask

  initial begin
    bus4.start = 1'b0; bus4.a = '0; bus4.b = '0; bus4.cin = 1'b0;
    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    test_reset();
    test_basic();
    test_carry();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid_run();
    test_exhaustive_n4();
    test_random_n8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
